// File: rtl/cache_line_xfer_pkg.sv
// Shared types and constants for the cache line transfer engine.
//   xfer_state_e : burst engine states
//   LINE_WORDS   : default words per cache line
//   DATA_WIDTH   : default bits per word
//   line_t       : a line as a packed array of words, word 0 in the low bits
package cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } xfer_state_e;

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

endpackage

// File: rtl/cache_line_xfer.sv
// Line-granular burst engine between the cache refill/evict logic and the
// fetch port of the memory controller. One line request is taken at a time;
// a refill reads line_words consecutive words and returns the assembled line,
// a writeback writes line_words words from the supplied line.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    line request handshake
//   req_write              1 = writeback, 0 = refill
//   req_line_addr          line index
//   req_wline              writeback line, word i at [i*data_width +: data_width]
//   rsp_valid/rsp_ready    completion handshake
//   rsp_rline              refilled (or written) line, same packing
//   fetch_mem_raddr/ren/rready/rdata/rdata_valid   word read port
//   fetch_mem_waddr/wen/wready/wdata               word write port
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int mem_depth  = 32,
  parameter int data_width = 32,
  parameter int line_words = LINE_WORDS
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic                                     req_write,
  input  logic [$clog2(mem_depth/line_words)-1:0]  req_line_addr,
  input  logic [line_words*data_width-1:0]         req_wline,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [line_words*data_width-1:0]         rsp_rline,
  output logic [$clog2(mem_depth)-1:0]             fetch_mem_raddr,
  output logic                                     fetch_mem_ren,
  input  logic                                     fetch_mem_rready,
  input  logic [data_width-1:0]                    fetch_mem_rdata,
  input  logic                                     fetch_mem_rdata_valid,
  output logic [$clog2(mem_depth)-1:0]             fetch_mem_waddr,
  output logic                                     fetch_mem_wen,
  input  logic                                     fetch_mem_wready,
  output logic [data_width-1:0]                    fetch_mem_wdata
);

  localparam int OFS_W   = $clog2(line_words);
  localparam int CNT_W   = OFS_W + 1;
  localparam int ADDR_W  = $clog2(mem_depth);
  localparam int LADDR_W = $clog2(mem_depth / line_words);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(line_words - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(line_words);

  xfer_state_e                            state_q, state_d;
  logic [LADDR_W-1:0]                     line_addr_q, line_addr_d;
  logic [CNT_W-1:0]                       issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]                       rx_cnt_q, rx_cnt_d;
  logic [line_words-1:0][data_width-1:0]  buf_q, buf_d;

  logic [ADDR_W-1:0] word_addr;
  logic              capture;
  logic [CNT_W-1:0]  rx_next;

  // Word offsets ascend 0..line_words-1 inside the selected line.
  assign word_addr = ADDR_W'({line_addr_q, issue_cnt_q[OFS_W-1:0]});

  // Read data is shared with the other memory port, so it is only taken while
  // a refill is actually outstanding; rx_next already counts a same-cycle
  // capture so the last word can be recognised without an extra cycle.
  assign capture = fetch_mem_rdata_valid && ((state_q == RD) || (state_q == RD_WAIT));
  assign rx_next = rx_cnt_q + CNT_W'(capture);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      buf_q       <= buf_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    line_addr_d     = line_addr_q;
    issue_cnt_d     = issue_cnt_q;
    rx_cnt_d        = rx_cnt_q;
    buf_d           = buf_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rline       = '0;
    fetch_mem_ren   = 1'b0;
    fetch_mem_raddr = '0;
    fetch_mem_wen   = 1'b0;
    fetch_mem_waddr = '0;
    fetch_mem_wdata = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_addr_d = req_line_addr;
          buf_d       = req_wline;
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          state_d     = req_write ? WR : RD;
        end
      end

      RD: begin
        fetch_mem_ren   = 1'b1;
        fetch_mem_raddr = word_addr;
        if (fetch_mem_rready) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_IDX) begin
            state_d = (rx_next == FULL_CNT) ? RESP : RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (rx_next == FULL_CNT) begin
          state_d = RESP;
        end
      end

      WR: begin
        fetch_mem_wen   = 1'b1;
        fetch_mem_waddr = word_addr;
        fetch_mem_wdata = buf_q[issue_cnt_q[OFS_W-1:0]];
        if (fetch_mem_wready) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_IDX) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        rsp_rline = buf_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Returned words arrive in issue order, so rx_cnt is the slot to fill.
    if (capture) begin
      buf_d[rx_cnt_q[OFS_W-1:0]] = fetch_mem_rdata;
      rx_cnt_d                   = rx_next;
    end
  end

endmodule

// File: doc/cache_line_xfer.md
Name: cache_line_xfer

Overview:
- Line-granular burst engine driving the fetch port (fetch_mem_*) of the memory controller.
- Accepts one cache-line request at a time from the cache refill/evict logic:
  - refill: read line_words consecutive words and return the assembled line;
  - writeback: write line_words words from a supplied line.
- Hides per-word ren/rready and wen/wready handshakes and the 1-cycle read latency from the cache.

Parameters:
- mem_depth, 32, words in backing memory; multiple of line_words.
- data_width, 32, bits per word.
- line_words, 4, words per line; power of 2, >=2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  line request valid.
- req_ready  output  1  engine idle, accepts request.
- req_write  input  1  1 = writeback, 0 = refill.
- req_line_addr  input  $clog2(mem_depth/line_words)  line index.
- req_wline  input  line_words*data_width  writeback data; word i at bits [i*data_width +: data_width].
- rsp_valid  output  1  transfer complete; rsp_rline valid for refill.
- rsp_ready  input  1  consumer takes response.
- rsp_rline  output  line_words*data_width  refilled line; same packing as req_wline.
- fetch_mem_raddr  output  $clog2(mem_depth)  word read address.
- fetch_mem_ren  output  1  read request.
- fetch_mem_rready  input  1  read grant.
- fetch_mem_rdata  input  data_width  read data.
- fetch_mem_rdata_valid  input  1  read data valid, 1 cycle after read handshake.
- fetch_mem_waddr  output  $clog2(mem_depth)  word write address.
- fetch_mem_wen  output  1  write request.
- fetch_mem_wready  input  1  write grant.
- fetch_mem_wdata  output  data_width  write data.

Behaviour:
- Reset (rst_n low at posedge clk): state IDLE, counters 0, line buffer 0. Outputs:
  - req_ready=1 (IDLE);
  - rsp_valid=0, fetch_mem_ren=0, fetch_mem_wen=0;
  - addresses, wdata and rsp_rline = 0.
- Reset mid-transfer aborts immediately. No further ren/wen is issued. A late fetch_mem_rdata_valid after reset is ignored.
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch line addr, req_write and req_wline into the line buffer; clear issue_cnt and rx_cnt.
  - Go to WR if req_write, else RD.
- Word address: {line_addr, issue_cnt[$clog2(line_words)-1:0]}, offsets ascending 0..line_words-1.
- RD:
  - fetch_mem_ren=1, raddr = current word address.
  - Handshake = ren && rready; issue_cnt increments on each handshake.
  - rready low holds ren and address stable; no gaps inserted, back-to-back issue allowed.
  - After the handshake of the last word: go to RD_WAIT if rx_cnt+incoming < line_words, else RESP.
- Capture:
  - In RD or RD_WAIT, each fetch_mem_rdata_valid writes fetch_mem_rdata to buffer word rx_cnt, then rx_cnt++.
  - fetch_mem_rdata is shared with the other port; sample only on fetch_mem_rdata_valid.
- RD_WAIT:
  - ren=0.
  - When rx_cnt reaches line_words (including same-cycle capture of the final word), go to RESP next cycle.
- WR:
  - fetch_mem_wen=1, waddr = word address, wdata = buffer word issue_cnt.
  - Advance on wen && wready.
  - After the last handshake go to RESP. No write response is awaited.
- RESP:
  - rsp_valid=1 and rsp_rline = buffer, held stable until rsp_ready.
  - On rsp_valid && rsp_ready go to IDLE.
  - For writeback, rsp_rline shows the written line.
- req_ready=0 outside IDLE.
- Refill latency with rready held high: ren for line_words cycles starting the cycle after acceptance; rsp_valid rises line_words+2 cycles after acceptance.
- Writeback latency with wready held high: rsp_valid rises line_words+1 cycles after acceptance.
- Counters are $clog2(line_words)+1 bits wide; never wrap within a line.
- ren and wen are never asserted together.
- rdata_valid in IDLE, WR or RESP is ignored.

Decomposition:
- cache_pkg holds:
  - the xfer_state_e enum (IDLE, RD, RD_WAIT, WR, RESP);
  - the LINE_WORDS default constant;
  - a line_t packed-array typedef helper.
- Single module. No sub-module is warranted; the counters and line buffer are inline.

Test Plan:
All cases use mem_depth=32, line_words=4, data_width=32.
- Refill, rready=1: mem[8..11]=A0..A3, req_line_addr=2 -> raddr 8,9,10,11 on consecutive cycles; rsp_valid 6 cycles after acceptance; rsp_rline={A3,A2,A1,A0}.
- Refill with rready low 2 cycles on word 1 -> raddr holds 9 during the stall; 4 handshakes total; rline unchanged content; rsp_valid delayed 2 cycles.
- Writeback line 7, req_wline={D3,D2,D1,D0}, wready toggling 1,0,1 -> waddr/wdata 28/D0, 29/D1 (held while wready=0), 30/D2, 31/D3; memory then holds D0..D3 at 28..31.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rline stable, req_ready=0; after the rsp_ready pulse, IDLE with req_ready=1.
- Reset mid-refill after 2 handshakes -> next cycle ren=0, rsp_valid=0, req_ready=1; the pending rdata_valid is ignored; a following refill returns correct data.
- Back-to-back requests: refill line 0 then writeback line 1 with req_valid held -> second accepted only after the first RESP handshake; no ren/wen overlap.
